// File: rtl/posit_div.sv
// posit_div: iterative posit divider, out = in1 / in2.
// Operands are decoded into scale and mantissa, the mantissas are divided
// by restoring shift-subtract (one quotient bit per clock) and the result
// is repacked with truncation and saturation to minpos/maxpos.
module posit_div #(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5,
    parameter int ES        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] in1,
    input  logic [WORD_SIZE-1:0] in2,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] out,
    output logic                 inf,
    output logic                 zero,
    output logic                 valid
);

    localparam int N  = WORD_SIZE;
    localparam int F  = N - ES - 2;
    localparam int KW = RS + 2;
    localparam int SW = RS + ES + 2;
    localparam int CW = $clog2(F + 2);
    localparam int MAXSCALE = (N - 2) << ES;

    localparam logic [N-1:0]         NAR       = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]         MAXPOS    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]         MINPOS    = {{(N-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] SCALE_MAX = SW'(MAXSCALE);
    localparam logic signed [SW-1:0] SCALE_MIN = SW'(-MAXSCALE);
    localparam logic [CW-1:0]        CNT_INIT  = CW'(F + 1);

    typedef enum logic [1:0] {IDLE, DECODE, DIVIDE, PACK} state_t;

    typedef struct packed {
        logic signed [SW-1:0] scale;
        logic [F:0]           mant;
    } dec_t;

    // Split a finite nonzero posit into its signed scale and hidden-one mantissa.
    function automatic dec_t decodeMag(input logic [N-1:0] x);
        logic [N-2:0]   rest;
        logic [N-3:0]   tail;
        logic           regBit;
        logic           done;
        logic [RS:0]    run;
        logic [KW-1:0]  runExt;
        logic [KW-1:0]  k;
        dec_t           d;
        rest   = x[N-1] ? (~x[N-2:0] + (N-1)'(1)) : x[N-2:0];
        regBit = rest[N-2];
        run    = '0;
        done   = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done) begin
                if (rest[i] == regBit) run = run + (RS+1)'(1);
                else                   done = 1'b1;
            end
        end
        // Drop the remaining regime bits and the terminating bit.
        tail    = rest[N-3:0] << run;
        runExt  = KW'(run);
        k       = regBit ? (runExt - KW'(1)) : (KW'(0) - runExt);
        d.scale = $signed({k, tail[N-3 -: ES]});
        d.mant  = {1'b1, tail[F-1:0]};
        return d;
    endfunction

    // Build the posit bit pattern for a sign, scale and truncated fraction.
    function automatic logic [N-1:0] packPosit(input logic sgn,
                                               input logic signed [SW-1:0] sc,
                                               input logic [F-1:0] frac);
        logic [N-1:0]         mag;
        logic signed [KW-1:0] k;
        logic [KW-1:0]        shamt;
        logic signed [N-1:0]  body;
        if (sc > SCALE_MAX) begin
            mag = MAXPOS;
        end else if (sc < SCALE_MIN) begin
            mag = MINPOS;
        end else begin
            k = $signed(sc[SW-1:ES]);
            if (!k[KW-1]) begin
                shamt = k;
                body  = $signed({2'b10, sc[ES-1:0], frac}) >>> shamt;
            end else begin
                shamt = ~k;
                body  = $signed({2'b01, sc[ES-1:0], frac}) >> shamt;
            end
            mag = $unsigned(body) >> 1;
        end
        return sgn ? (~mag + N'(1)) : mag;
    endfunction

    state_t                state_q;
    logic [N-1:0]          opA_q, opB_q;
    logic                  sign_q;
    logic signed [SW-1:0]  scale_q;
    logic [F+1:0]          rem_q;
    logic [F:0]            divisor_q;
    logic [F+1:0]          q_q;
    logic [CW-1:0]         cnt_q;
    logic                  specInf_q, specZero_q;
    logic [N-1:0]          out_q;
    logic                  inf_q, zero_q, valid_q, busy_q;

    dec_t                  decA_d, decB_d;
    logic                  isInf_d, isZero_d;
    logic                  remGe_d;
    logic [F+1:0]          remSub_d, rem_d, q_d;
    logic signed [SW-1:0]  packScale_d;
    logic [F-1:0]          packFrac_d;
    logic [N-1:0]          packOut_d;

    // Operand classification and field extraction from the latched operands.
    always_comb begin
        decA_d   = decodeMag(opA_q);
        decB_d   = decodeMag(opB_q);
        isInf_d  = (opA_q == NAR) || (opB_q == NAR) || (opB_q == '0);
        isZero_d = !isInf_d && (opA_q == '0);
    end

    // One restoring division step: compare, conditionally subtract, shift.
    always_comb begin
        remGe_d  = (rem_q >= {1'b0, divisor_q});
        remSub_d = remGe_d ? (rem_q - {1'b0, divisor_q}) : rem_q;
        rem_d    = remSub_d << 1;
        q_d      = {q_q[F:0], remGe_d};
    end

    // Normalise the quotient into [1, 2) and encode the result.
    always_comb begin
        if (q_q[F+1]) begin
            packScale_d = scale_q;
            packFrac_d  = q_q[F:1];
        end else begin
            packScale_d = scale_q - SW'(1);
            packFrac_d  = q_q[F-1:0];
        end
        packOut_d = packPosit(sign_q, packScale_d, packFrac_d);
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            sign_q     <= 1'b0;
            scale_q    <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            specInf_q  <= 1'b0;
            specZero_q <= 1'b0;
            out_q      <= '0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q   <= in1;
                        opB_q   <= in2;
                        busy_q  <= 1'b1;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    sign_q     <= opA_q[N-1] ^ opB_q[N-1];
                    scale_q    <= decA_d.scale - decB_d.scale;
                    rem_q      <= {1'b0, decA_d.mant};
                    divisor_q  <= decB_d.mant;
                    q_q        <= '0;
                    cnt_q      <= CNT_INIT;
                    specInf_q  <= isInf_d;
                    specZero_q <= isZero_d;
                    state_q    <= (isInf_d || isZero_d) ? PACK : DIVIDE;
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    if (cnt_q == '0) state_q <= PACK;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                PACK: begin
                    if (specInf_q)       out_q <= NAR;
                    else if (specZero_q) out_q <= '0;
                    else                 out_q <= packOut_d;
                    inf_q   <= specInf_q;
                    zero_q  <= specZero_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign inf   = inf_q;
    assign zero  = zero_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_posit_div.sv
// tb_posit_div: directed vectors, multi-cycle corner sequences and random
// operands checked against a value-level posit division model.
module tb_posit_div;

    localparam logic [31:0] NAR    = 32'h80000000;
    localparam logic [31:0] MAXPOS = 32'h7FFFFFFF;
    localparam logic [31:0] MINPOS = 32'h00000001;
    localparam int NUMVEC = 17;
    localparam int NUMRAND = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1, in2;
    logic        busy;
    logic [31:0] out;
    logic        inf, zero, valid;

    int checks = 0;
    int failures = 0;

    posit_div #(.WORD_SIZE(32), .RS(5), .ES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .out(out), .inf(inf), .zero(zero), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOut;
        logic        expInf;
        logic        expZero;
        int          expLat;
    } vec_t;

    vec_t vecs [NUMVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation and wait (bounded) for its valid pulse.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] gotOut, output logic gotInf,
                                 output logic gotZero, output int lat, output logic gotBusy);
        logic seen;
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        gotBusy = busy;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) seen = 1'b1;
        end
        if (!seen) lat = -1;
        gotOut = out;
        gotInf = inf;
        gotZero = zero;
    endtask

    // Read a positive posit field by field into mantissa (28 fraction bits) and scale.
    function automatic void modelDecode(input logic [31:0] p, output longint mant, output int scale);
        int pos;
        int run;
        int k;
        int e;
        logic r;
        pos = 30;
        r = p[30];
        run = 0;
        while (pos >= 0 && p[pos] == r) begin
            run++;
            pos--;
        end
        k = r ? run - 1 : -run;
        pos--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2;
            if (pos >= 0 && p[pos]) e = e + 1;
            pos--;
        end
        mant = 1;
        for (int j = 0; j < 28; j++) begin
            mant = mant * 2;
            if (pos >= 0 && p[pos]) mant = mant + 1;
            pos--;
        end
        scale = k * 4 + e;
    endfunction

    // True when value(p) <= (aM / bM) * 2^(aS - bS), evaluated exactly.
    function automatic bit posLeq(input logic [31:0] p, input longint aM, input int aS,
                                  input longint bM, input int bS);
        longint pM;
        int pS;
        longint lhs;
        int d;
        modelDecode(p, pM, pS);
        lhs = pM * bM;
        d = (aS - bS) - (pS - 28);
        if (d < 0) return 1'b0;
        if (d > 31) return 1'b1;
        return lhs <= (aM << d);
    endfunction

    // Quotient = largest posit not above |in1/in2|, clamped to minpos, then signed.
    function automatic void modelDiv(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] eOut, output logic eInf, output logic eZero);
        logic [31:0] ma, mb;
        longint aM, bM, lo, hi, mid, res;
        int aS, bS;
        eInf = 1'b0;
        eZero = 1'b0;
        if (a == NAR || b == NAR || b == 32'h0) begin
            eOut = NAR;
            eInf = 1'b1;
        end else if (a == 32'h0) begin
            eOut = 32'h0;
            eZero = 1'b1;
        end else begin
            ma = a[31] ? 32'h0 - a : a;
            mb = b[31] ? 32'h0 - b : b;
            modelDecode(ma, aM, aS);
            modelDecode(mb, bM, bS);
            lo = 1;
            hi = 64'h7FFFFFFF;
            res = 1;
            while (lo <= hi) begin
                mid = lo + (hi - lo) / 2;
                if (posLeq(mid[31:0], aM, aS, bM, bS)) begin
                    res = mid;
                    lo = mid + 1;
                end else begin
                    hi = mid - 1;
                end
            end
            eOut = (a[31] ^ b[31]) ? 32'h0 - res[31:0] : res[31:0];
        end
    endfunction

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0: return 32'h0;
            1: return NAR;
            2: return MAXPOS;
            3: return MINPOS;
            4: return 32'h80000001;
            5: return $urandom & 32'h0000FFFF;
            6: return 32'h7FFF0000 | ($urandom & 32'h0000FFFF);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] gOut, eOut, a, b;
        logic        gInf, gZero, gBusy, eInf, eZero;
        int          lat, pulses;

        vecs[0]  = '{32'h50000000, 32'h48000000, 32'h48000000, 1'b0, 1'b0, 32};
        vecs[1]  = '{32'h40000000, 32'h4C000000, 32'h32AAAAAA, 1'b0, 1'b0, 32};
        vecs[2]  = '{32'h40000000, 32'h48000000, 32'h38000000, 1'b0, 1'b0, 32};
        vecs[3]  = '{32'hC0000000, 32'h48000000, 32'hC8000000, 1'b0, 1'b0, 32};
        vecs[4]  = '{32'h40000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[5]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[6]  = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 32};
        vecs[7]  = '{32'h00000001, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32};
        vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[9]  = '{32'h40000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[10] = '{32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[11] = '{32'h48000000, 32'h48000000, 32'h40000000, 1'b0, 1'b0, 32};
        vecs[12] = '{32'hB0000000, 32'hB8000000, 32'h48000000, 1'b0, 1'b0, 32};
        vecs[13] = '{32'h40000000, 32'hB4000000, 32'hCD555556, 1'b0, 1'b0, 32};
        vecs[14] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h40000000, 1'b0, 1'b0, 32};
        vecs[15] = '{32'h7FFFFFFF, 32'h38000000, 32'h7FFFFFFF, 1'b0, 1'b0, 32};
        vecs[16] = '{32'h00000001, 32'h48000000, 32'h00000001, 1'b0, 1'b0, 32};

        rst = 1'b1;
        start = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out", out, 32'h0);
        checkOutput("reset inf", {31'b0, inf}, 32'h0);
        checkOutput("reset zero", {31'b0, zero}, 32'h0);
        checkOutput("reset valid", {31'b0, valid}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NUMVEC; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, gOut, gInf, gZero, lat, gBusy);
            checkOutput($sformatf("vec%0d out", i), gOut, vecs[i].expOut);
            checkOutput($sformatf("vec%0d inf", i), {31'b0, gInf}, {31'b0, vecs[i].expInf});
            checkOutput($sformatf("vec%0d zero", i), {31'b0, gZero}, {31'b0, vecs[i].expZero});
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d busy", i), {31'b0, gBusy}, 32'h1);
        end

        // Reset in the middle of a division discards it without a valid pulse.
        applyStimulus(32'h50000000, 32'h48000000, gOut, gInf, gZero, lat, gBusy);
        checkOutput("rstMid prior out", gOut, 32'h48000000);
        @(negedge clk);
        in1 = 32'h40000000;
        in2 = 32'h4C000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstMid out", out, 32'h0);
        checkOutput("rstMid busy", {31'b0, busy}, 32'h0);
        checkOutput("rstMid valid", {31'b0, valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        checkOutput("rstMid no valid", pulses, 0);
        checkOutput("rstMid idle busy", {31'b0, busy}, 32'h0);

        // A start pulse while busy is ignored: exactly one result appears.
        @(negedge clk);
        in1 = 32'h50000000;
        in2 = 32'h48000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyStart busy", {31'b0, busy}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        in1 = 32'h40000000;
        in2 = 32'h4C000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        gOut = '0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                gOut = out;
            end
        end
        checkOutput("busyStart pulses", pulses, 1);
        checkOutput("busyStart out", gOut, 32'h48000000);

        // Start raised in the valid cycle is accepted at the next edge.
        applyStimulus(32'h40000000, 32'h48000000, gOut, gInf, gZero, lat, gBusy);
        checkOutput("b2b first out", gOut, 32'h38000000);
        in1 = 32'hC0000000;
        in2 = 32'h48000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b valid one cycle", {31'b0, valid}, 32'h0);
        checkOutput("b2b busy", {31'b0, busy}, 32'h1);
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b2b latency", lat, 32);
        checkOutput("b2b out", out, 32'hC8000000);

        // Random operands against the value-level model.
        for (int i = 0; i < NUMRAND; i++) begin
            a = pickOperand();
            b = pickOperand();
            modelDiv(a, b, eOut, eInf, eZero);
            applyStimulus(a, b, gOut, gInf, gZero, lat, gBusy);
            checkOutput($sformatf("rand%0d out %08h/%08h", i, a, b), gOut, eOut);
            checkOutput($sformatf("rand%0d inf", i), {31'b0, gInf}, {31'b0, eInf});
            checkOutput($sformatf("rand%0d zero", i), {31'b0, gZero}, {31'b0, eZero});
            checkOutput($sformatf("rand%0d latency", i), lat, (eInf || eZero) ? 2 : 32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
